// File: rtl/CPU_buffer_bus.sv
// Shared pipeline-buffer types for the front end of the CPU.
//   if_id_bus_t   : payload handed from the fetch stage to the IF/ID register.
//   fetch_state_e : state encoding of the instruction-fetch FSM.
package CPU_buffer_bus;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
  } if_id_bus_t;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  localparam logic [31:0] PC_STEP = 32'd4;

  // Redirect targets are word addresses; the two low bits carry no meaning.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage. Owns the PC, issues one instruction-memory request
// at a time, holds a returned word while IF/ID is stalled, applies redirects
// and throws away responses that belong to squashed fetches.
//
// Ports
//   ACLK, ARESET        : clock (rising edge), synchronous active-high reset
//   stall_en            : IF/ID holds this cycle; presented word not consumed
//   redirect_en/_pc     : squash current fetch and restart at redirect_pc
//   imem_req_*          : request channel (valid/ready, addr)
//   imem_rsp_*          : response channel (valid, data, ready tied high)
//   if_id_bus_out       : {pc, inst, valid} toward IF/ID, all zero when !valid
//   fetch_state         : current FSM state, exported for observation
//
// Handshake rule: a request transfers on a rising edge where imem_req_valid
// and imem_req_ready are both high; a response transfers on any edge where
// imem_rsp_valid is high (imem_rsp_ready is always 1). At most one request
// is outstanding, so no new request is raised until the response is seen.
module if_fetch_unit
  import CPU_buffer_bus::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         ACLK,
  input  logic         ARESET,
  input  logic         stall_en,
  input  logic         redirect_en,
  input  logic [31:0]  redirect_pc,
  output logic         imem_req_valid,
  input  logic         imem_req_ready,
  output logic [31:0]  imem_req_addr,
  input  logic         imem_rsp_valid,
  input  logic [31:0]  imem_rsp_data,
  output logic         imem_rsp_ready,
  output if_id_bus_t   if_id_bus_out,
  output fetch_state_e fetch_state
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  inst_q;
  logic [31:0]  target_pc;
  logic         req_fire;

  assign target_pc = word_align(redirect_pc);
  assign req_fire  = imem_req_valid && imem_req_ready;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
    end else begin
      case (state_q)
        REQ: begin
          // A response showing up here is illegal and simply ignored.
          if (redirect_en) begin
            pc_q    <= target_pc;
            // The request already left for the old PC: its answer is an orphan.
            state_q <= req_fire ? DROP : REQ;
          end else if (req_fire) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (redirect_en) begin
            pc_q    <= target_pc;
            state_q <= imem_rsp_valid ? REQ : DROP;
          end else if (imem_rsp_valid) begin
            if (stall_en) begin
              inst_q  <= imem_rsp_data;
              state_q <= HOLD;
            end else begin
              pc_q    <= pc_q + PC_STEP;
              state_q <= REQ;
            end
          end
        end
        HOLD: begin
          if (redirect_en) begin
            pc_q    <= target_pc;
            state_q <= REQ;
          end else if (!stall_en) begin
            pc_q    <= pc_q + PC_STEP;
            state_q <= REQ;
          end
        end
        DROP: begin
          if (redirect_en) pc_q <= target_pc;
          if (imem_rsp_valid) state_q <= REQ;
        end
        default: state_q <= REQ;
      endcase
    end
  end

  // Outputs are decoded from state so a WAIT-state response reaches IF/ID
  // in the same cycle it arrives; reset forces the quiet values.
  always_comb begin
    imem_req_valid = 1'b0;
    if_id_bus_out  = '0;
    if (!ARESET) begin
      case (state_q)
        REQ:  imem_req_valid = 1'b1;
        WAIT: begin
          if (imem_rsp_valid && !redirect_en) begin
            if_id_bus_out.pc    = pc_q;
            if_id_bus_out.inst  = imem_rsp_data;
            if_id_bus_out.valid = 1'b1;
          end
        end
        HOLD: begin
          if_id_bus_out.pc    = pc_q;
          if_id_bus_out.inst  = inst_q;
          if_id_bus_out.valid = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign imem_req_addr  = pc_q;
  assign imem_rsp_ready = 1'b1;
  assign fetch_state    = state_q;

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage producer that generates `if_id_bus_t` for the IF/ID pipeline register. Owns the program counter, issues one word request at a time to instruction memory, and holds a returned instruction while the pipeline stalls. Applies control-flow redirects and discards responses belonging to squashed fetches. Sits between instruction memory and the IF/ID register, driven by the same `stall_en` that freezes that register.

## Interface
- `RESET_PC`, 32'h0000_0000, PC fetched first after reset.
- `ACLK` in 1: sole clock, rising edge.
- `ARESET` in 1: synchronous, active-high reset.
- `stall_en` in 1: IF/ID holds this cycle; the presented instruction is not consumed.
- `redirect_en` in 1: squash the current fetch and restart at `redirect_pc`.
- `redirect_pc` in 32: redirect target, word aligned.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_req_addr` out 32: fetch address.
- `imem_rsp_valid` in 1: response word valid.
- `imem_rsp_data` in 32: instruction word.
- `imem_rsp_ready` out 1: tied 1.
- `if_id_bus_out` out `if_id_bus_t`: fields `pc[31:0]`, `inst[31:0]`, `valid`.

## Operation
- State `pc_q` holds the fetch PC.
- State `inst_q` holds a captured instruction.
- FSM states:
  - `REQ`: drive `imem_req_valid=1` and `imem_req_addr=pc_q`.
    - Handshake and no redirect -> `WAIT`.
    - Handshake and `redirect_en` -> `pc_q<=redirect_pc`, -> `DROP`.
    - No handshake and `redirect_en` -> `pc_q<=redirect_pc`, stay in `REQ`. The address changes under valid; imem tolerates this.
  - `WAIT`:
    - No `imem_rsp_valid`, with `redirect_en` -> `pc_q<=redirect_pc`, -> `DROP`.
    - `imem_rsp_valid`, with `redirect_en` -> discard the word, `pc_q<=redirect_pc`, -> `REQ`.
    - `imem_rsp_valid`, no redirect, `!stall_en` -> present `{pc_q, imem_rsp_data, 1}` combinationally, consumed; `pc_q<=pc_q+4`, -> `REQ`.
    - `imem_rsp_valid`, no redirect, `stall_en` -> present the same values, `inst_q<=imem_rsp_data`, -> `HOLD`.
  - `HOLD`: present `{pc_q, inst_q, 1}`.
    - `redirect_en` -> `pc_q<=redirect_pc`, -> `REQ`.
    - `!stall_en` -> consumed, `pc_q<=pc_q+4`, -> `REQ`.
  - `DROP`: waiting for the orphan response.
    - `imem_rsp_valid` -> discard, -> `REQ`.
    - `redirect_en` -> `pc_q<=redirect_pc`, remain in `DROP` (or -> `REQ` if the response arrives the same cycle).
- Priority: `ARESET` > `redirect_en` > `stall_en`.
- `if_id_bus_out` is all zero whenever `valid=0`. It is never valid in `REQ` or `DROP`.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 = 32'h0.
- `redirect_pc[1:0]` is ignored and treated as 0.
- At most one request is outstanding. A request is never issued while one is outstanding.

## Timing
- Reset (`ARESET` high at an edge):
  - `pc_q=RESET_PC`, `inst_q=0`, state `REQ`.
  - While `ARESET` is high: `imem_req_valid=0` and `if_id_bus_out='0`.
- First request is visible the cycle after `ARESET` falls.
- Reset mid-fetch: any later response to the abandoned request is ignored while in `REQ`. The memory must not return it after reset; this is a system rule.
- Minimum request-to-present latency is 1 cycle (request handshake edge -> `WAIT`, response the next cycle). Peak throughput is one instruction per 2 cycles.
- A response arriving in `REQ` (illegal) is ignored.
- `imem_rsp_ready` is constant 1 in all states, including reset.

## Structure
- The `fetch_state_e` enum (`REQ`, `WAIT`, `HOLD`, `DROP`) is defined in `CPU_buffer_bus` alongside `if_id_bus_t`.
- `RESET_PC` stays a module parameter.
- Single module with no sub-module. The FSM, `pc_q` and `inst_q` are inline.

## Test plan
- Reset release, memory ready and 1-cycle response returning 32'h00000013 at 0x0, then 32'h00100093 at 0x4 -> `if_id_bus_out` valid with pc 0x0 then 0x4. Requests are at 0x0, 0x4, 0x8 in alternating cycles.
- Response 32'hDEADBEEF at pc 0x8 with `stall_en` held 3 cycles -> state `HOLD`, output constant {0x8, 32'hDEADBEEF, 1} for 3 cycles. No new request until stall drops; next request at 0xC.
- `redirect_en` with target 0x100 in `WAIT` before the response; response arrives 2 cycles later -> the response is discarded (`valid=0`), the next request is at 0x100, and the next valid output has pc 0x100.
- `redirect_en` with target 0x200 in the same cycle as `imem_rsp_valid`, with `stall_en` also high -> no valid output, `pc_q=0x200`, state `REQ` next cycle.
- `imem_req_ready` low for 4 cycles with `redirect_en` (0x40) in the second -> `imem_req_addr` switches to 0x40 and stays stable until the handshake.
- `ARESET` asserted in `HOLD` with `RESET_PC`=0x1000 -> output zero, `imem_req_valid=0` during reset. First request after release is at 0x1000.
